// File: rtl/reg_file_wb_pkg.sv
// Shared bus widths, types and constants for the write-back register file.
package reg_file_wb_pkg;

  localparam int DATA_BUS_WIDTH     = 32;
  localparam int REG_ADDR_BUS_WIDTH = 5;

  typedef logic [DATA_BUS_WIDTH-1:0]     data_bus_t;
  typedef logic [REG_ADDR_BUS_WIDTH-1:0] reg_addr_bus_t;

  localparam reg_addr_bus_t REG_ZERO = 5'd0;

  // A write only commits when enabled and not aimed at the hardwired zero register.
  function automatic logic eff_write(input logic en, input reg_addr_bus_t addr);
    return en && (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/reg_file_wb_if.sv
// MEM/WB write-back, ID read-port and debug-trace signals of the register file.
interface reg_file_wb_if
  import reg_file_wb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_BUS_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_BUS_WIDTH
);

  logic                  write_reg_en;
  logic [ADDR_WIDTH-1:0] write_reg_addr;
  logic [DATA_WIDTH-1:0] result;
  logic [31:0]           wb_pc;

  logic                  read_en_1;
  logic [ADDR_WIDTH-1:0] read_addr_1;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic                  read_en_2;
  logic [ADDR_WIDTH-1:0] read_addr_2;
  logic [DATA_WIDTH-1:0] read_data_2;

  logic [31:0]           debug_wb_pc;
  logic [3:0]            debug_wb_rf_wen;
  logic [ADDR_WIDTH-1:0] debug_wb_rf_wnum;
  logic [DATA_WIDTH-1:0] debug_wb_rf_wdata;

  // Pipeline / ID side: drives write-back and read requests, observes data and trace.
  modport master (
    output write_reg_en, write_reg_addr, result, wb_pc,
    output read_en_1, read_addr_1, read_en_2, read_addr_2,
    input  read_data_1, read_data_2,
    input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  // Register file side.
  modport slave (
    input  write_reg_en, write_reg_addr, result, wb_pc,
    input  read_en_1, read_addr_1, read_en_2, read_addr_2,
    output read_data_1, read_data_2,
    output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

endinterface

// File: rtl/reg_file_wb_read_port.sv
// One combinational read port: enable gating, r0 forcing, write-back bypass, array data.
module reg_file_wb_read_port
  import reg_file_wb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_BUS_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_BUS_WIDTH
) (
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] array_data,
  output logic [DATA_WIDTH-1:0] read_data
);

  // Priority mux: disabled or r0 reads give 0, a matching write-back wins over the array.
  always_comb begin
    read_data = '0;
    if (!read_en || (read_addr == '0)) begin
      read_data = '0;
    end else if (we && (read_addr == write_addr)) begin
      read_data = write_data;
    end else begin
      read_data = array_data;
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// Write-back stage register file: 32 x 32 storage, two bypassed read ports, debug trace.
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_BUS_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_BUS_WIDTH,
  parameter int REG_COUNT  = 2 ** ADDR_WIDTH
) (
  input logic         clk,
  input logic         rst,
  reg_file_wb_if.slave bus
);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic                  we;

  assign we = eff_write(bus.write_reg_en, bus.write_reg_addr);

  // Storage: reset clears everything and overrides a concurrent write; r0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[bus.write_reg_addr] <= bus.result;
    end
  end

  reg_file_wb_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_read_port_1 (
    .read_en   (bus.read_en_1),
    .read_addr (bus.read_addr_1),
    .we        (we),
    .write_addr(bus.write_reg_addr),
    .write_data(bus.result),
    .array_data(regs[bus.read_addr_1]),
    .read_data (bus.read_data_1)
  );

  reg_file_wb_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_read_port_2 (
    .read_en   (bus.read_en_2),
    .read_addr (bus.read_addr_2),
    .we        (we),
    .write_addr(bus.write_reg_addr),
    .write_data(bus.result),
    .array_data(regs[bus.read_addr_2]),
    .read_data (bus.read_data_2)
  );

  // Debug trace mirrors the current WB cycle; write enables are suppressed while in reset.
  always_comb begin
    bus.debug_wb_pc       = bus.wb_pc;
    bus.debug_wb_rf_wen   = rst ? 4'b0000 : {4{we}};
    bus.debug_wb_rf_wnum  = bus.write_reg_addr;
    bus.debug_wb_rf_wdata = bus.result;
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb.
module tb_reg_file_wb;
  import reg_file_wb_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  reg_file_wb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  reg_file_wb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .REG_COUNT(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.write_reg_en   = 1'b0;
    bus.write_reg_addr = '0;
    bus.result         = '0;
    bus.wb_pc          = '0;
    bus.read_en_1      = 1'b0;
    bus.read_addr_1    = '0;
    bus.read_en_2      = 1'b0;
    bus.read_addr_2    = '0;
  endtask

  task automatic drive_wb(input logic en, input logic [4:0] addr, input logic [31:0] data,
                          input logic [31:0] pc);
    bus.write_reg_en   = en;
    bus.write_reg_addr = addr;
    bus.result         = data;
    bus.wb_pc          = pc;
  endtask

  task automatic drive_rd(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    bus.read_en_1   = e1;
    bus.read_addr_1 = a1;
    bus.read_en_2   = e2;
    bus.read_addr_2 = a2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_wb(1'b1, 5'd4, 32'h0000_1111, 32'hBFC0_0000);
    #1;
    vectors++;
    if (bus.debug_wb_rf_wen !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_wen got %b want 0000", bus.debug_wb_rf_wen);
    end
    tick();
    rst = 1'b0;
    idle();
    for (int a = 0; a < 32; a++) begin
      drive_rd(1'b1, a[4:0], 1'b1, a[4:0]);
      #1;
      vectors++;
      if (bus.read_data_1 !== 32'h0 || bus.read_data_2 !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_read r%0d got %h/%h want 0", a, bus.read_data_1, bus.read_data_2);
      end
    end
  endtask

  task automatic test_write_read();
    idle();
    drive_wb(1'b1, 5'd5, 32'hDEAD_BEEF, 32'hBFC0_0010);
    #1;
    vectors++;
    if (bus.debug_wb_rf_wen !== 4'b1111 || bus.debug_wb_rf_wnum !== 5'd5 ||
        bus.debug_wb_rf_wdata !== 32'hDEAD_BEEF || bus.debug_wb_pc !== 32'hBFC0_0010) begin
      miscompares++;
      $display("FAIL write_trace got wen=%b num=%0d data=%h pc=%h want 1111/5/deadbeef/bfc00010",
               bus.debug_wb_rf_wen, bus.debug_wb_rf_wnum, bus.debug_wb_rf_wdata, bus.debug_wb_pc);
    end
    tick();
    idle();
    drive_rd(1'b1, 5'd5, 1'b1, 5'd5);
    #1;
    vectors++;
    if (bus.read_data_1 !== 32'hDEAD_BEEF || bus.read_data_2 !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL write_read got %h/%h want deadbeef", bus.read_data_1, bus.read_data_2);
    end
  endtask

  task automatic test_bypass();
    idle();
    drive_wb(1'b1, 5'd7, 32'h1234_5678, 32'hBFC0_0014);
    drive_rd(1'b1, 5'd7, 1'b1, 5'd7);
    #1;
    vectors++;
    if (bus.read_data_1 !== 32'h1234_5678 || bus.read_data_2 !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL bypass got %h/%h want 12345678", bus.read_data_1, bus.read_data_2);
    end
    tick();
    drive_wb(1'b0, 5'd0, 32'h0, 32'h0);
    #1;
    vectors++;
    if (bus.read_data_1 !== 32'h1234_5678 || bus.read_data_2 !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL bypass_commit got %h/%h want 12345678", bus.read_data_1, bus.read_data_2);
    end
    // A bypass on port 1 must not disturb an unrelated read on port 2.
    drive_wb(1'b1, 5'd7, 32'hCAFE_0001, 32'hBFC0_0018);
    drive_rd(1'b1, 5'd7, 1'b1, 5'd5);
    #1;
    vectors++;
    if (bus.read_data_1 !== 32'hCAFE_0001 || bus.read_data_2 !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL bypass_split got %h/%h want cafe0001/deadbeef", bus.read_data_1, bus.read_data_2);
    end
    tick();
  endtask

  task automatic test_r0();
    idle();
    drive_wb(1'b1, 5'd0, 32'hFFFF_FFFF, 32'hBFC0_0020);
    drive_rd(1'b1, 5'd0, 1'b1, 5'd0);
    #1;
    vectors++;
    if (bus.read_data_1 !== 32'h0 || bus.read_data_2 !== 32'h0) begin
      miscompares++;
      $display("FAIL r0_same_cycle got %h/%h want 0", bus.read_data_1, bus.read_data_2);
    end
    vectors++;
    if (bus.debug_wb_rf_wen !== 4'b0000) begin
      miscompares++;
      $display("FAIL r0_trace_wen got %b want 0000", bus.debug_wb_rf_wen);
    end
    tick();
    drive_wb(1'b0, 5'd0, 32'h0, 32'h0);
    #1;
    vectors++;
    if (bus.read_data_1 !== 32'h0 || bus.read_data_2 !== 32'h0) begin
      miscompares++;
      $display("FAIL r0_after got %h/%h want 0", bus.read_data_1, bus.read_data_2);
    end
  endtask

  task automatic test_read_enable();
    idle();
    drive_wb(1'b1, 5'd3, 32'h0000_0055, 32'hBFC0_0030);
    tick();
    idle();
    drive_rd(1'b1, 5'd3, 1'b0, 5'd3);
    #1;
    vectors++;
    if (bus.read_data_2 !== 32'h0 || bus.read_data_1 !== 32'h55) begin
      miscompares++;
      $display("FAIL rd_en2_off got p1=%h p2=%h want 55/0", bus.read_data_1, bus.read_data_2);
    end
    drive_rd(1'b0, 5'd3, 1'b1, 5'd3);
    #1;
    vectors++;
    if (bus.read_data_2 !== 32'h55 || bus.read_data_1 !== 32'h0) begin
      miscompares++;
      $display("FAIL rd_en1_off got p1=%h p2=%h want 0/55", bus.read_data_1, bus.read_data_2);
    end
    // Disabled port also ignores a matching bypass.
    drive_wb(1'b1, 5'd3, 32'h0000_0077, 32'hBFC0_0034);
    drive_rd(1'b0, 5'd3, 1'b1, 5'd3);
    #1;
    vectors++;
    if (bus.read_data_1 !== 32'h0 || bus.read_data_2 !== 32'h77) begin
      miscompares++;
      $display("FAIL rd_en_bypass got p1=%h p2=%h want 0/77", bus.read_data_1, bus.read_data_2);
    end
    drive_wb(1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic test_reset_priority();
    idle();
    rst = 1'b1;
    drive_wb(1'b1, 5'd9, 32'h0000_00AA, 32'hBFC0_0040);
    drive_rd(1'b1, 5'd3, 1'b1, 5'd9);
    #1;
    vectors++;
    if (bus.read_data_1 !== 32'h55 || bus.read_data_2 !== 32'hAA) begin
      miscompares++;
      $display("FAIL rst_read_path got %h/%h want 55/aa", bus.read_data_1, bus.read_data_2);
    end
    vectors++;
    if (bus.debug_wb_rf_wen !== 4'b0000 || bus.debug_wb_rf_wnum !== 5'd9) begin
      miscompares++;
      $display("FAIL rst_trace got wen=%b num=%0d want 0000/9", bus.debug_wb_rf_wen, bus.debug_wb_rf_wnum);
    end
    tick();
    rst = 1'b0;
    idle();
    drive_rd(1'b1, 5'd9, 1'b1, 5'd5);
    #1;
    vectors++;
    if (bus.read_data_1 !== 32'h0 || bus.read_data_2 !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_priority got r9=%h r5=%h want 0/0", bus.read_data_1, bus.read_data_2);
    end
    drive_wb(1'b1, 5'd9, 32'h0000_00BB, 32'hBFC0_0044);
    tick();
    drive_wb(1'b0, 5'd0, 32'h0, 32'h0);
    drive_rd(1'b1, 5'd9, 1'b1, 5'd9);
    #1;
    vectors++;
    if (bus.read_data_1 !== 32'hBB || bus.read_data_2 !== 32'hBB) begin
      miscompares++;
      $display("FAIL rst_rewrite got %h/%h want bb", bus.read_data_1, bus.read_data_2);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    drive_wb(1'b1, 5'd10, 32'hA5A5_0010, 32'hBFC0_0050);
    tick();
    drive_wb(1'b1, 5'd31, 32'h5A5A_0031, 32'hBFC0_0054);
    drive_rd(1'b1, 5'd10, 1'b1, 5'd31);
    #1;
    vectors++;
    if (bus.read_data_1 !== 32'hA5A5_0010 || bus.read_data_2 !== 32'h5A5A_0031) begin
      miscompares++;
      $display("FAIL b2b_mid got %h/%h want a5a50010/5a5a0031", bus.read_data_1, bus.read_data_2);
    end
    tick();
    idle();
    drive_rd(1'b1, 5'd31, 1'b1, 5'd10);
    #1;
    vectors++;
    if (bus.read_data_1 !== 32'h5A5A_0031 || bus.read_data_2 !== 32'hA5A5_0010) begin
      miscompares++;
      $display("FAIL b2b_after got %h/%h want 5a5a0031/a5a50010", bus.read_data_1, bus.read_data_2);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    idle();
    #2;
    test_reset();
    test_write_read();
    test_bypass();
    test_r0();
    test_read_enable();
    test_reset_priority();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
